sort_step_sequencer: RTL and testbench

- Controller sitting between the push-button/switch inputs and the bubble-sort engine.
- Decides when the engine advances one compare/swap step:
  - free-running at a selectable rate,
  - paused,
  - single-stepped forward,
  - stepped backward, using an internal history stack of recent steps.
- The engine performs the actual compare/swap; this block only schedules it and replays undo records.

---
 rtl/sort_step_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_sort_step_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_step_sequencer.sv
// Step scheduler for the bubble-sort engine: free-run, pause, single step
// forward and undo via a circular history of completed compare/swap steps.
module sort_step_sequencer #(
  parameter int STEP_DELAY      = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int IDX_W           = 3,
  parameter int HIST_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sw_enable,
  input  logic                          sw_run,
  input  logic                          btn_pause,
  input  logic                          btn_next,
  input  logic                          btn_prev,
  input  logic [1:0]                    rate_sel,
  output logic                          step_req,
  input  logic                          step_ack,
  input  logic                          step_swapped,
  input  logic [IDX_W-1:0]              step_idx,
  input  logic                          sort_done,
  output logic                          undo_req,
  output logic [IDX_W-1:0]              undo_idx,
  output logic                          undo_swap,
  input  logic                          undo_ack,
  output logic                          running,
  output logic                          paused,
  output logic                          finished,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);

  localparam int CNT_W = $clog2(STEP_DELAY + 2);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int HC_W  = PTR_W + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_FULL = HC_W'(HIST_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_WAIT, S_RUN_REQ, S_PAUSED, S_STEP_REQ, S_UNDO_REQ, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Button path: two synchronizer stages, then per-button debounce counters.
  logic [2:0]      btn_raw;
  logic [2:0]      sync_p0, sync_p1;
  logic [2:0]      db_level;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];
  logic            pause_press, next_press, prev_press;

  assign btn_raw     = {btn_prev, btn_next, btn_pause};
  assign pause_press = press[0];
  assign next_press  = press[1];
  assign prev_press  = press[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level <= '0;
      press    <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        press[b] <= 1'b0;
        if (sync_p1[b] == db_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] >= DB_LAST) begin
          db_level[b] <= sync_p1[b];
          press[b]    <= sync_p1[b];
          db_cnt[b]   <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // Auto-step delay; a zero threshold is stretched to one cycle.
  logic [CNT_W-1:0] delay_cnt, delay_thr;
  logic             wait_done;

  always_comb begin
    delay_thr = CNT_W'(STEP_DELAY >> rate_sel);
    if (delay_thr == '0) delay_thr = CNT_W'(1);
  end

  assign wait_done = (delay_cnt + CNT_W'(1)) >= delay_thr;

  // History stack: pointer addresses the next free slot, wrapping over the oldest.
  logic [IDX_W:0]   hist_mem [HIST_DEPTH];
  logic [PTR_W-1:0] hist_ptr;
  logic [IDX_W:0]   hist_top;
  logic             push, pop, hist_clr;

  assign hist_top = hist_mem[hist_ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (push) hist_mem[hist_ptr] <= {step_swapped, step_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_ptr   <= '0;
      hist_count <= '0;
    end else if (hist_clr) begin
      hist_ptr   <= '0;
      hist_count <= '0;
    end else if (push) begin
      hist_ptr <= hist_ptr + PTR_W'(1);
      if (hist_count != HC_FULL) hist_count <= hist_count + HC_W'(1);
    end else if (pop) begin
      hist_ptr   <= hist_ptr - PTR_W'(1);
      hist_count <= hist_count - HC_W'(1);
    end
  end

  // Control FSM
  logic pause_pend, pend_nxt, cnt_clr, cnt_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pause_pend <= 1'b0;
      delay_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      pause_pend <= pend_nxt;
      if (cnt_clr)      delay_cnt <= '0;
      else if (cnt_inc) delay_cnt <= delay_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pause_pend;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    hist_clr  = 1'b0;
    if (!sw_enable) begin
      state_nxt = S_IDLE;
      pend_nxt  = 1'b0;
      hist_clr  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (sw_run) begin
            state_nxt = S_RUN_WAIT;
            cnt_clr   = 1'b1;
          end
        end
        S_RUN_WAIT: begin
          cnt_inc = 1'b1;
          if (!sw_run)          state_nxt = S_PAUSED;
          else if (sort_done)   state_nxt = S_DONE;
          else if (pause_press) state_nxt = S_PAUSED;
          else if (wait_done) begin
            state_nxt = S_RUN_REQ;
            cnt_clr   = 1'b1;
          end
        end
        S_RUN_REQ: begin
          if (pause_press) pend_nxt = 1'b1;
          if (step_ack) begin
            push     = 1'b1;
            pend_nxt = 1'b0;
            cnt_clr  = 1'b1;
            if (pause_press || pause_pend || !sw_run) state_nxt = S_PAUSED;
            else                                      state_nxt = S_RUN_WAIT;
          end
        end
        S_PAUSED: begin
          if (pause_press) begin
            state_nxt = S_RUN_WAIT;
            cnt_clr   = 1'b1;
          end else if (next_press) begin
            if (!sort_done) state_nxt = S_STEP_REQ;
          end else if (prev_press && hist_count != '0) begin
            state_nxt = S_UNDO_REQ;
          end
        end
        S_STEP_REQ: begin
          if (step_ack) begin
            push      = 1'b1;
            state_nxt = S_PAUSED;
          end
        end
        S_UNDO_REQ: begin
          if (undo_ack) begin
            pop       = 1'b1;
            state_nxt = S_PAUSED;
          end
        end
        S_DONE: begin
          if (prev_press && hist_count != '0) state_nxt = S_UNDO_REQ;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign step_req  = (state == S_RUN_REQ) || (state == S_STEP_REQ);
  assign undo_req  = (state == S_UNDO_REQ);
  assign undo_idx  = undo_req ? hist_top[IDX_W-1:0] : '0;
  assign undo_swap = undo_req & hist_top[IDX_W];
  assign running   = (state == S_RUN_WAIT) || (state == S_RUN_REQ);
  assign paused    = (state == S_PAUSED) || (state == S_STEP_REQ) || (state == S_UNDO_REQ);
  assign finished  = (state == S_DONE);

endmodule

// File: tb/tb_sort_step_sequencer.sv
// Bench for sort_step_sequencer: vector table, hand sequences for multi-cycle
// corners, and randomized step/undo traffic against a queue-based history model.
module tb_sort_step_sequencer;

  localparam int IDX_W = 3;
  localparam int HD    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sw_enable, sw_run, btn_pause, btn_next, btn_prev;
  logic [1:0]       rate_sel;
  logic             step_req, step_ack, step_swapped, sort_done;
  logic [IDX_W-1:0] step_idx;
  logic             undo_req, undo_swap, undo_ack;
  logic [IDX_W-1:0] undo_idx;
  logic             running, paused, finished;
  logic [2:0]       hist_count;

  sort_step_sequencer #(
    .STEP_DELAY(8), .DEBOUNCE_CYCLES(50), .IDX_W(IDX_W), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_enable(sw_enable), .sw_run(sw_run),
    .btn_pause(btn_pause), .btn_next(btn_next), .btn_prev(btn_prev),
    .rate_sel(rate_sel), .step_req(step_req), .step_ack(step_ack),
    .step_swapped(step_swapped), .step_idx(step_idx), .sort_done(sort_done),
    .undo_req(undo_req), .undo_idx(undo_idx), .undo_swap(undo_swap),
    .undo_ack(undo_ack), .running(running), .paused(paused),
    .finished(finished), .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDX_W:0] hq[$];

  typedef struct packed {
    logic       en, run, ack, done, swp;
    logic [2:0] idx;
    logic [4:0] exp_flags;  // {running, paused, finished, step_req, undo_req}
    logic [2:0] exp_hist;
  } vec_t;
  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_sig(input int sel, input int max_cyc, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if ((sel == 0) ? step_req : undo_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: request not seen within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic push_model(input logic [IDX_W:0] v);
    hq.push_back(v);
    if (hq.size() > HD) void'(hq.pop_front());
  endtask

  // Hold a button long enough for the debouncer to accept both edges.
  task automatic press(input int b);
    if (b == 0) btn_pause = 1'b1; else if (b == 1) btn_next = 1'b1; else btn_prev = 1'b1;
    repeat (60) tick();
    btn_pause = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    repeat (60) tick();
  endtask

  task automatic go_paused();
    sw_enable = 1'b0; tick();
    sw_enable = 1'b1; sw_run = 1'b1; tick();
    sw_run = 1'b0; tick();
    hq.delete();
    check("go_paused", paused, 1);
  endtask

  task automatic do_step(input logic [IDX_W-1:0] idx, input logic sw, input int dly);
    bit ok;
    bit dropped;
    press(1);
    if (sort_done) begin
      check("next_ignored_done", step_req, 0);
      return;
    end
    wait_sig(0, 10, "step_req_seen", ok);
    if (!ok) return;
    dropped = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!step_req) dropped = 1'b1;
    end
    check("step_req_held", dropped, 0);
    step_idx = idx; step_swapped = sw; step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    push_model({sw, idx});
    check("step_hist", hist_count, hq.size());
    check("step_back_paused", {paused, step_req}, 2'b10);
  endtask

  task automatic do_undo(input int dly);
    bit ok;
    logic [IDX_W:0] top;
    press(2);
    if (hq.size() == 0) begin
      check("prev_ignored", undo_req, 0);
      check("prev_ignored_hist", hist_count, 0);
      return;
    end
    wait_sig(1, 10, "undo_req_seen", ok);
    if (!ok) return;
    top = hq[hq.size()-1];
    check("undo_idx", undo_idx, top[IDX_W-1:0]);
    check("undo_swap", undo_swap, top[IDX_W]);
    repeat (dly) tick();
    check("undo_idx_stable", {undo_req, undo_swap, undo_idx}, {1'b1, top});
    undo_ack = 1'b1;
    tick();
    undo_ack = 1'b0;
    void'(hq.pop_back());
    check("undo_hist", hist_count, hq.size());
    check("undo_back_paused", {paused, undo_req, finished}, 3'b100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int t_last, t_now, n_rise;
    bit prev_req, dropped;
    logic [IDX_W-1:0] ridx;
    logic rsw;

    reset_n = 1'b0; sw_enable = 1'b0; sw_run = 1'b0;
    btn_pause = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    rate_sel = 2'd3; step_ack = 1'b0; step_swapped = 1'b0; step_idx = '0;
    sort_done = 1'b0; undo_ack = 1'b0;
    #1;
    check("reset_outputs", {step_req, undo_req, undo_idx, undo_swap, running, paused, finished}, 0);
    check("reset_hist", hist_count, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", {running, paused, finished, step_req, undo_req}, 0);

    // Table: rate_sel=3 gives a one-cycle auto delay.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10000, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10010, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10010, 3'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 5'b10000, 3'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10010, 3'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10010, 3'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'b01000, 3'd2};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b01000, 3'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b10000, 3'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00100, 3'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00100, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0};
    for (int i = 0; i < 13; i++) begin
      sw_enable = tbl[i].en; sw_run = tbl[i].run; step_ack = tbl[i].ack;
      sort_done = tbl[i].done; step_swapped = tbl[i].swp; step_idx = tbl[i].idx;
      tick();
      check($sformatf("vec%0d_flags", i), {running, paused, finished, step_req, undo_req}, tbl[i].exp_flags);
      check($sformatf("vec%0d_hist", i), hist_count, tbl[i].exp_hist);
    end
    step_ack = 1'b0; sort_done = 1'b0;

    // Auto run: delay 8>>1 = 4 cycles, ack one cycle after the request.
    rate_sel = 2'd1; sw_enable = 1'b1; sw_run = 1'b1; hq.delete();
    tick();
    t_last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_sig(0, 40, "auto_req", ok);
      if (!ok) break;
      t_now = cyc;
      if (k > 0) check("auto_period", t_now - t_last, 6);
      t_last = t_now;
      tick();
      ridx = IDX_W'($urandom_range(0, 7)); rsw = 1'($urandom_range(0, 1));
      step_idx = ridx; step_swapped = rsw; step_ack = 1'b1;
      tick();
      step_ack = 1'b0;
      push_model({rsw, ridx});
      check("auto_hist", hist_count, hq.size());
    end
    sort_done = 1'b1;
    tick();
    check("auto_finished", finished, 1);
    n_rise = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_req) n_rise++;
    end
    check("done_no_step", n_rise, 0);
    do_undo(1);
    check("undo_from_done_unfinished", finished, 0);
    sort_done = 1'b0;

    // Pause press while a step request is outstanding.
    sw_enable = 1'b0; tick();
    check("override_clears_hist", hist_count, 0);
    rate_sel = 2'd0; sw_enable = 1'b1; sw_run = 1'b1;
    tick();
    wait_sig(0, 30, "pause_run_req", ok);
    dropped = 1'b0;
    btn_pause = 1'b1;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (!step_req) dropped = 1'b1;
    end
    check("req_held_through_pause", dropped, 0);
    step_idx = 3'd1; step_swapped = 1'b0; step_ack = 1'b1;
    tick();
    step_ack = 1'b0; btn_pause = 1'b0;
    check("pause_on_ack", paused, 1);
    check("pause_on_ack_hist", hist_count, 1);
    n_rise = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step_req || !paused) n_rise++;
    end
    check("paused_no_new_step", n_rise, 0);

    // Single step then undo it.
    go_paused();
    do_step(3'd2, 1'b1, 2);
    do_undo(2);
    check("step_undo_hist_zero", hist_count, 0);

    // History overflow: depth 4, six steps.
    go_paused();
    for (int i = 0; i < 6; i++) do_step(IDX_W'(i), i[0], 1);
    check("ovf_hist_sat", hist_count, 4);
    for (int i = 0; i < 5; i++) do_undo(0);

    // Bouncing next button.
    go_paused();
    n_rise = 0; prev_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_next = ((i / 10) % 2 == 0);
      tick();
      if (step_req && !prev_req) n_rise++;
      prev_req = step_req;
    end
    check("bounce_quiet", n_rise, 0);
    btn_next = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (step_req && !prev_req) n_rise++;
      prev_req = step_req;
    end
    check("bounce_one_step", n_rise, 1);
    check("bounce_req_held", step_req, 1);
    step_idx = 3'd4; step_swapped = 1'b0; step_ack = 1'b1;
    tick();
    step_ack = 1'b0; btn_next = 1'b0;
    repeat (70) tick();
    check("bounce_hist", hist_count, 1);

    // Randomized step/undo traffic against the history model.
    go_paused();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        sort_done = ($urandom_range(0, 5) == 0);
        do_step(IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        sort_done = 1'b0;
      end else begin
        do_undo($urandom_range(0, 4));
      end
      check("rand_hist", hist_count, hq.size());
    end

    // Reset while a step request is pending.
    go_paused();
    do_step(3'd6, 1'b1, 0);
    press(1);
    check("pre_reset_req", step_req, 1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_outputs", {step_req, undo_req, running, paused, finished}, 0);
    check("reset_mid_hist", hist_count, 0);
    #3;
    reset_n = 1'b1;
    sw_run = 1'b0;
    tick();
    check("post_reset_hist", hist_count, 0);
    check("post_reset_idle", {running, paused, finished, step_req}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
